// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving a shared 4:1 mux, with a bounded grant hold time.
// Optional grant lock input is enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] x,
`ifdef MUX4_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       y
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_last;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_win;
    logic             w_lock;
    logic             w_max;
    logic             w_others;
    logic             w_take;
`ifdef MUX4_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif
    // Scan from farthest to nearest so the nearest requester after r_last wins.
    always_comb begin
        w_win = r_last;
        for (int i = 3; i >= 0; i--)
            if (req[r_last + 2'(i + 1)]) w_win = r_last + 2'(i + 1);
    end
    assign w_max    = r_cnt == CNT_W'(MAX_HOLD);
    assign w_others = |(req & ~r_gnt);
    assign w_take   = (r_state == IDLE) ? |req :
                      !req[r_sel]       ? |req :
                      (w_max && w_others && !w_lock);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_state <= GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_last  <= w_win;
            r_cnt   <= CNT_W'(1);
        end else if (r_state == GRANT && !req[r_sel]) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
        end else if (r_state == GRANT && !w_max) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign y    = r_busy ? x[r_sel] : 1'b0;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: table-driven directed checks of the round-robin mux arbiter (MAX_HOLD=4).
module tb_mux4_rr_arbiter;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] x;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       y;
    } vec_t;
    vec_t       tbl[$];
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] x = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    int         n_chk = 0;
    int         n_pass = 0;
`ifdef MUX4_ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk(clk), .reset(rst), .req(req), .x(x),
`ifdef MUX4_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .sel(sel), .busy(busy), .y(y)
    );
    always #5 clk = ~clk;
    function automatic void add(logic r, logic [3:0] rq, logic [3:0] xv, logic [3:0] g, logic [1:0] s, logic b, logic yv);
        tbl.push_back('{rst: r, req: rq, x: xv, gnt: g, sel: s, busy: b, y: yv});
    endfunction
    task automatic check(string name, logic [3:0] g, logic [1:0] s, logic b, logic yv);
        n_chk++;
        if (gnt === g && sel === s && busy === b && y === yv) n_pass++;
        else $display("FAIL %s: got gnt=%b sel=%0d busy=%b y=%b, want gnt=%b sel=%0d busy=%b y=%b",
                      name, gnt, sel, busy, y, g, s, b, yv);
    endtask
    task automatic step(logic r, logic [3:0] rq, logic [3:0] xv);
        rst = r;
        req = rq;
        x   = xv;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [3:0] xd;
        xd = 4'b1101;
        add(1, 4'b0000, xd, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, xd, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, xd, 4'b0000, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                add(0, 4'b1111, xd, 4'b0001 << k, 2'(k), 1, xd[k]);
        add(0, 4'b1111, xd, 4'b0001, 0, 1, 1);
        add(0, 4'b0100, xd, 4'b0100, 2, 1, 1);
        add(0, 4'b0000, xd, 4'b0000, 2, 0, 0);
        for (int c = 0; c < 10; c++)
            add(0, 4'b0010, xd, 4'b0010, 1, 1, 0);
        add(0, 4'b1010, xd, 4'b1000, 3, 1, 1);
        add(0, 4'b0000, xd, 4'b0000, 3, 0, 0);
        add(0, 4'b1001, xd, 4'b0001, 0, 1, 1);
        add(1, 4'b1111, xd, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, xd, 4'b0001, 0, 1, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].x);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].y);
        end
        // y follows x combinationally while owner 0 holds the grant
        x = 4'b1110;
        #1;
        check("y_comb_0", 4'b0001, 0, 1, 0);
        x = 4'b0001;
        #1;
        check("y_comb_1", 4'b0001, 0, 1, 1);
`ifdef MUX4_ARB_LOCK_EN
        step(1, 4'b0000, xd);
        check("lock_rst", 4'b0000, 0, 0, 0);
        step(0, 4'b0010, xd);
        check("lock_own1", 4'b0010, 1, 1, 0);
        lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(0, 4'b1111, xd);
            check($sformatf("lock_hold%0d", c), 4'b0010, 1, 1, 0);
        end
        lock = 1'b0;
        step(0, 4'b1111, xd);
        check("lock_release", 4'b0100, 2, 1, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
